iris_feature_loader: RTL and testbench
======================================

// Module: iris_feature_loader
// PURPOSE
//  Upstream front end for the registered iris decision-tree classifier. Takes a
//  byte stream over valid/ready (4 bytes per sample) and saturates each byte to
//  a 5-bit feature. It presents the four features, held stable, to the
//  classifier, waits out the classifier latency, then returns the class with a
//  sequence number over a valid/ready output handshake.
// PARAMETERS
//  QSHIFT   0   right shift applied to each raw byte before 5-bit saturation
//  CLS_LAT  1   classifier latency in clk cycles, features-in to target-out (>=1)
//  SEQ_W    8   width of the sample sequence counter
// PORTS
//  clk              in   1      clock, all logic on rising edge
//  reset            in   1      synchronous, active-high
//  s_valid          in   1      input byte valid
//  s_ready          out  1      loader accepts a byte (beat = s_valid & s_ready)
//  s_data           in   8      raw feature byte
//  s_first          in   1      marks byte 0 of a frame
//  f_petal_length   out  5      feature to classifier
//  f_sepal_width    out  5      feature to classifier
//  f_petal_width    out  5      feature to classifier
//  f_sepal_length   out  5      feature to classifier
//  cls_target       in   3      classifier result
//  m_valid          out  1      result valid
//  m_ready          in   1      downstream accepts the result
//  m_class          out  3      captured cls_target
//  m_seq            out  SEQ_W  sample index, wraps modulo 2^SEQ_W
//  frame_err        out  1      1-cycle pulse on resync
// BEHAVIOUR
//  - Reset: state=COLLECT, byte count=0. s_ready=1 from the first cycle after reset.
//  - Reset clears all f_* = 0, m_valid=0, m_class=0, m_seq=0, frame_err=0.
//  - Reset mid-operation aborts any frame in progress and discards a pending result.
//  - Frame byte order: petal_length, sepal_width, petal_width, sepal_length.
//  - Quantise: q = (s_data >> QSHIFT); feature = (q > 31) ? 31 : q[4:0].
//  - Features 0-2 go to shadow regs. On beat 3, all four f_* update in the same edge.
//  - f_* never change during EVAL or OUT, and hold until the next frame's beat 3.
//  - FSM:
//    COLLECT: s_ready=1, m_valid=0. Count beats 0..3. Beat 3 -> EVAL.
//    EVAL: s_ready=0. Lasts exactly CLS_LAT+1 cycles.
//      On the final EVAL edge, m_class<=cls_target and m_valid<=1 -> OUT.
//    OUT: s_ready=0. m_valid, m_class and m_seq are held stable while m_ready=0.
//      On m_valid & m_ready: m_valid<=0, m_seq<=m_seq+1 (wraps), count<=0 -> COLLECT.
//  - Latency: m_valid rises CLS_LAT+1 edges after the beat-3 edge (2 for the default).
//  - Throughput: at most one sample per 4+CLS_LAT+2 cycles. No overlap of frames.
//  - Resync on s_first:
//    Beat with s_first=1 at count!=0: discard the partial frame, take this byte as
//      byte 0 (count becomes 1), pulse frame_err for one cycle.
//    s_first=1 at count==0: normal byte 0. s_first=0 at count==0: accepted as byte 0.
//  - s_data is ignored when no beat occurs. m_class is never X after reset.
// CONFIGURATION
//  - Macro IRIS_LOADER_STATS_EN.
//  - Defined: adds out ports cnt_c1, cnt_c2, cnt_c3, cnt_bad (16 each).
//    Each counter increments on an output handshake for m_class = 1 / 2 / 3 /
//      any other value respectively.
//    Counters saturate at 16'hFFFF and clear only on reset.
//  - Undefined: these ports and their logic do not exist. All other behaviour is identical.
// TESTING
//  1 Reset held 3 cycles then released -> all outputs 0, s_ready=1.
//  2 Bytes 10,2,2,20, s_first on byte 0, m_ready=1 -> f_*=10,2,2,20.
//    m_valid high 2 edges after the beat-3 edge, m_class=3'b001, m_seq=0.
//    Next frame gives m_seq=1.
//  3 Byte 200, QSHIFT=0 -> feature 31. Byte 200, QSHIFT=3 -> feature 25.
//  4 m_ready=0 for 5 cycles after m_valid -> m_valid, m_class, m_seq stable, s_ready=0.
//    Result is consumed on the first cycle m_ready=1.
//  5 Two bytes, then s_first=1 byte -> frame_err pulses 1 cycle, count=1.
//    The next 3 bytes complete the frame from the resync byte.
//  6 Reset asserted during EVAL -> no m_valid, state COLLECT, m_seq=0.
//    With IRIS_LOADER_STATS_EN: 3 class-2 results -> cnt_c2=3.

Source files
------------

// File: rtl/iris_feature_loader.sv
// Byte-stream front end for the iris classifier: quantises 4 bytes per sample, holds features, returns class + sequence number.
// Optional per-class result counters are built only when IRIS_LOADER_STATS_EN is defined.
module iris_feature_loader #(
  parameter int QSHIFT  = 0,
  parameter int CLS_LAT = 1,
  parameter int SEQ_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_first,
  output logic [4:0]       f_petal_length,
  output logic [4:0]       f_sepal_width,
  output logic [4:0]       f_petal_width,
  output logic [4:0]       f_sepal_length,
  input  logic [2:0]       cls_target,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [2:0]       m_class,
  output logic [SEQ_W-1:0] m_seq,
  output logic             frame_err
`ifdef IRIS_LOADER_STATS_EN
  ,
  output logic [15:0]      cnt_c1,
  output logic [15:0]      cnt_c2,
  output logic [15:0]      cnt_c3,
  output logic [15:0]      cnt_bad
`endif
);

  localparam int EW = $clog2(CLS_LAT + 2);

  typedef enum logic [1:0] {COLLECT, EVAL, OUT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [EW-1:0]    ev_q, ev_d;
  logic [4:0]       sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [4:0]       fpl_q, fpl_d, fsw_q, fsw_d, fpw_q, fpw_d, fsl_q, fsl_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [2:0]       m_class_q, m_class_d;
  logic [SEQ_W-1:0] m_seq_q, m_seq_d;
  logic             frame_err_q, frame_err_d;
  logic             beat, hs;
  logic [4:0]       qd;

  function automatic logic [4:0] quant(input logic [7:0] d);
    logic [7:0] q;
    q = d >> QSHIFT;
    return (q > 8'd31) ? 5'd31 : q[4:0];
  endfunction

  assign beat = s_valid & s_ready_q;
  assign hs   = m_valid_q & m_ready;
  assign qd   = quant(s_data);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ev_d        = ev_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    fpl_d       = fpl_q;
    fsw_d       = fsw_q;
    fpw_d       = fpw_q;
    fsl_d       = fsl_q;
    s_ready_d   = s_ready_q;
    m_valid_d   = m_valid_q;
    m_class_d   = m_class_q;
    m_seq_d     = m_seq_q;
    frame_err_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (beat) begin
          // A first-marked byte mid-frame restarts the frame with itself as byte 0
          if (s_first && (cnt_q != 2'd0)) begin
            sh0_d       = qd;
            cnt_d       = 2'd1;
            frame_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
              2'd0: sh0_d = qd;
              2'd1: sh1_d = qd;
              2'd2: sh2_d = qd;
              default: begin
                fpl_d     = sh0_q;
                fsw_d     = sh1_q;
                fpw_d     = sh2_q;
                fsl_d     = qd;
                ev_d      = '0;
                s_ready_d = 1'b0;
                state_d   = EVAL;
              end
            endcase
          end
        end
      end
      EVAL: begin
        if (ev_q == EW'(CLS_LAT)) begin
          m_class_d = cls_target;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else begin
          ev_d = ev_q + 1'b1;
        end
      end
      OUT: begin
        if (hs) begin
          m_valid_d = 1'b0;
          m_seq_d   = m_seq_q + 1'b1;
          cnt_d     = 2'd0;
          s_ready_d = 1'b1;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      ev_q        <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      fpl_q       <= '0;
      fsw_q       <= '0;
      fpw_q       <= '0;
      fsl_q       <= '0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      m_seq_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ev_q        <= ev_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      fpl_q       <= fpl_d;
      fsw_q       <= fsw_d;
      fpw_q       <= fpw_d;
      fsl_q       <= fsl_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_class_q   <= m_class_d;
      m_seq_q     <= m_seq_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_ready        = s_ready_q;
  assign f_petal_length = fpl_q;
  assign f_sepal_width  = fsw_q;
  assign f_petal_width  = fpw_q;
  assign f_sepal_length = fsl_q;
  assign m_valid        = m_valid_q;
  assign m_class        = m_class_q;
  assign m_seq          = m_seq_q;
  assign frame_err      = frame_err_q;

`ifdef IRIS_LOADER_STATS_EN
  logic [15:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d, cb_q, cb_d;

  always_comb begin
    c1_d = c1_q;
    c2_d = c2_q;
    c3_d = c3_q;
    cb_d = cb_q;
    if (hs) begin
      case (m_class_q)
        3'd1:    if (c1_q != 16'hFFFF) c1_d = c1_q + 16'd1;
        3'd2:    if (c2_q != 16'hFFFF) c2_d = c2_q + 16'd1;
        3'd3:    if (c3_q != 16'hFFFF) c3_d = c3_q + 16'd1;
        default: if (cb_q != 16'hFFFF) cb_d = cb_q + 16'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c1_q <= '0;
      c2_q <= '0;
      c3_q <= '0;
      cb_q <= '0;
    end else begin
      c1_q <= c1_d;
      c2_q <= c2_d;
      c3_q <= c3_d;
      cb_q <= cb_d;
    end
  end

  assign cnt_c1  = c1_q;
  assign cnt_c2  = c2_q;
  assign cnt_c3  = c3_q;
  assign cnt_bad = cb_q;
`endif

endmodule

// File: tb/tb_iris_feature_loader.sv
// Directed bench for iris_feature_loader: default instance plus a QSHIFT=3 instance on shared inputs.
module tb_iris_feature_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_first = 1'b0;
  logic [2:0] cls_target = 3'd0;
  logic       m_ready = 1'b0;

  logic       s_ready, m_valid, frame_err;
  logic [4:0] f_pl, f_sw, f_pw, f_sl;
  logic [2:0] m_class;
  logic [7:0] m_seq;

  logic       q3_s_ready, q3_m_valid, q3_frame_err;
  logic [4:0] q3_pl, q3_sw, q3_pw, q3_sl;
  logic [2:0] q3_m_class;
  logic [7:0] q3_m_seq;
`ifdef IRIS_LOADER_STATS_EN
  logic [15:0] cnt_c1, cnt_c2, cnt_c3, cnt_bad;
  logic [15:0] q3_c1, q3_c2, q3_c3, q3_bad;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  iris_feature_loader dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_first(s_first), .f_petal_length(f_pl), .f_sepal_width(f_sw), .f_petal_width(f_pw),
    .f_sepal_length(f_sl), .cls_target(cls_target), .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_seq(m_seq), .frame_err(frame_err)
`ifdef IRIS_LOADER_STATS_EN
    , .cnt_c1(cnt_c1), .cnt_c2(cnt_c2), .cnt_c3(cnt_c3), .cnt_bad(cnt_bad)
`endif
  );

  iris_feature_loader #(.QSHIFT(3)) dut_q3 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(q3_s_ready), .s_data(s_data),
    .s_first(s_first), .f_petal_length(q3_pl), .f_sepal_width(q3_sw), .f_petal_width(q3_pw),
    .f_sepal_length(q3_sl), .cls_target(cls_target), .m_valid(q3_m_valid), .m_ready(m_ready),
    .m_class(q3_m_class), .m_seq(q3_m_seq), .frame_err(q3_frame_err)
`ifdef IRIS_LOADER_STATS_EN
    , .cnt_c1(q3_c1), .cnt_c2(q3_c2), .cnt_c3(q3_c3), .cnt_bad(q3_bad)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f);
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    step();
    s_valid = 1'b0;
    s_first = 1'b0;
    s_data  = 8'hXX;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    send_byte(b3, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_valid = 1'b1;
    s_data = 8'd99;
    repeat (3) step();
    reset = 1'b0;
    s_valid = 1'b0;
    step();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    total++; if ({f_pl, f_sw, f_pw, f_sl} !== 20'd0) begin bad++; $display("FAIL reset_features got %h want 0", {f_pl, f_sw, f_pw, f_sl}); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    total++; if (m_class !== 3'd0) begin bad++; $display("FAIL reset_m_class got %0d want 0", m_class); end
    total++; if (m_seq !== 8'd0) begin bad++; $display("FAIL reset_m_seq got %0d want 0", m_seq); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    cls_target = 3'd1;
    send_frame(8'd10, 8'd2, 8'd2, 8'd20);
    total++; if ({f_pl, f_sw, f_pw, f_sl} !== {5'd10, 5'd2, 5'd2, 5'd20}) begin bad++; $display("FAIL basic_features got %0d,%0d,%0d,%0d want 10,2,2,20", f_pl, f_sw, f_pw, f_sl); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL basic_s_ready_eval got %b want 0", s_ready); end
    step();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_m_valid_early got %b want 0", m_valid); end
    step();
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_m_valid_lat2 got %b want 1", m_valid); end
    total++; if (m_class !== 3'b001) begin bad++; $display("FAIL basic_m_class got %0d want 1", m_class); end
    total++; if (m_seq !== 8'd0) begin bad++; $display("FAIL basic_m_seq0 got %0d want 0", m_seq); end
    step();
    total++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL basic_consume got m_valid=%b s_ready=%b want 0,1", m_valid, s_ready); end
    cls_target = 3'd2;
    send_frame(8'd1, 8'd1, 8'd1, 8'd1);
    step();
    step();
    total++; if (m_valid !== 1'b1 || m_seq !== 8'd1 || m_class !== 3'd2) begin bad++; $display("FAIL basic_second got v=%b seq=%0d cls=%0d want 1,1,2", m_valid, m_seq, m_class); end
    step();
  endtask

  task automatic test_quant();
    m_ready = 1'b1;
    cls_target = 3'd3;
    send_frame(8'd200, 8'd0, 8'd255, 8'd8);
    total++; if ({f_pl, f_sw, f_pw, f_sl} !== {5'd31, 5'd0, 5'd31, 5'd8}) begin bad++; $display("FAIL quant_shift0 got %0d,%0d,%0d,%0d want 31,0,31,8", f_pl, f_sw, f_pw, f_sl); end
    total++; if ({q3_pl, q3_sw, q3_pw, q3_sl} !== {5'd25, 5'd0, 5'd31, 5'd1}) begin bad++; $display("FAIL quant_shift3 got %0d,%0d,%0d,%0d want 25,0,31,1", q3_pl, q3_sw, q3_pw, q3_sl); end
    repeat (3) step();
    total++; if (m_seq !== 8'd3) begin bad++; $display("FAIL quant_seq got %0d want 3", m_seq); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    cls_target = 3'd5;
    send_frame(8'd1, 8'd2, 8'd3, 8'd4);
    step();
    step();
    total++; if (m_valid !== 1'b1 || m_class !== 3'd5) begin bad++; $display("FAIL bp_rise got v=%b cls=%0d want 1,5", m_valid, m_class); end
    cls_target = 3'd6;
    s_valid = 1'b1;
    s_data = 8'd30;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (m_valid !== 1'b1 || m_class !== 3'd5 || m_seq !== 8'd3 || s_ready !== 1'b0 || f_pl !== 5'd1 || f_sl !== 5'd4) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b cls=%0d seq=%0d rdy=%b pl=%0d sl=%0d want 1,5,3,0,1,4", i, m_valid, m_class, m_seq, s_ready, f_pl, f_sl);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    total++; if (m_valid !== 1'b0 || m_seq !== 8'd4 || s_ready !== 1'b1) begin bad++; $display("FAIL bp_release got v=%b seq=%0d rdy=%b want 0,4,1", m_valid, m_seq, s_ready); end
  endtask

  task automatic test_resync();
    m_ready = 1'b1;
    cls_target = 3'd3;
    send_byte(8'd7, 1'b1);
    send_byte(8'd8, 1'b0);
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_no_err got %b want 0", frame_err); end
    send_byte(8'd9, 1'b1);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL resync_err_pulse got %b want 1", frame_err); end
    step();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_err_one_cycle got %b want 0", frame_err); end
    send_byte(8'd11, 1'b0);
    send_byte(8'd12, 1'b0);
    total++; if (s_ready !== 1'b1 || f_pl !== 5'd1) begin bad++; $display("FAIL resync_not_done got rdy=%b pl=%0d want 1,1", s_ready, f_pl); end
    send_byte(8'd13, 1'b0);
    total++; if ({f_pl, f_sw, f_pw, f_sl} !== {5'd9, 5'd11, 5'd12, 5'd13}) begin bad++; $display("FAIL resync_frame got %0d,%0d,%0d,%0d want 9,11,12,13", f_pl, f_sw, f_pw, f_sl); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL resync_eval got rdy=%b want 0", s_ready); end
    repeat (3) step();
    total++; if (m_seq !== 8'd5) begin bad++; $display("FAIL resync_seq got %0d want 5", m_seq); end
  endtask

  task automatic test_reset_eval();
    m_ready = 1'b1;
    cls_target = 3'd1;
    send_frame(8'd3, 8'd3, 8'd3, 8'd3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    total++; if (m_valid !== 1'b0 || m_seq !== 8'd0 || s_ready !== 1'b1) begin bad++; $display("FAIL rst_eval got v=%b seq=%0d rdy=%b want 0,0,1", m_valid, m_seq, s_ready); end
    total++; if ({f_pl, f_sw, f_pw, f_sl} !== 20'd0) begin bad++; $display("FAIL rst_eval_features got %h want 0", {f_pl, f_sw, f_pw, f_sl}); end
    repeat (3) step();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_eval_no_result got %b want 0", m_valid); end
    send_frame(8'd4, 8'd4, 8'd4, 8'd4);
    step();
    step();
    total++; if (m_valid !== 1'b1 || m_seq !== 8'd0) begin bad++; $display("FAIL rst_eval_restart got v=%b seq=%0d want 1,0", m_valid, m_seq); end
    step();
  endtask

`ifdef IRIS_LOADER_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    m_ready = 1'b1;
    cls_target = 3'd2;
    for (int i = 0; i < 3; i++) begin
      send_frame(8'd5, 8'd5, 8'd5, 8'd5);
      repeat (3) step();
    end
    total++; if (cnt_c2 !== 16'd3) begin bad++; $display("FAIL stats_c2 got %0d want 3", cnt_c2); end
    total++; if (cnt_c1 !== 16'd0 || cnt_c3 !== 16'd0 || cnt_bad !== 16'd0) begin bad++; $display("FAIL stats_others got %0d,%0d,%0d want 0,0,0", cnt_c1, cnt_c3, cnt_bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_quant();
    test_backpressure();
    test_resync();
    test_reset_eval();
`ifdef IRIS_LOADER_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
